alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, multi-cycle execute-stage ALU, XLEN bits wide, with valid/ready handshakes on both the operand and result sides.
- Single-cycle ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
- Iterative ops: MUL (low half), DIVU, REMU, on a shared XLEN-cycle datapath.
- Sits between register read/operand select and writeback; the pipeline stalls on in_ready/out_valid.

Parameters:
- XLEN, 32, operand/result width in bits (power of 2, >= 8).
- SHW, $clog2(XLEN), shift-amount bits taken from b (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand/op presented
- in_ready  output  1  block can accept; = (state==IDLE) & !flush
- op  input  4  operation code (encoding below)
- a  input  XLEN  operand 1
- b  input  XLEN  operand 2 / shift amount / divisor
- flush  input  1  synchronous abort of any in-flight op
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  XLEN  registered result
- busy  output  1  high in CALC or DONE

Behaviour:
- Reset: state IDLE, out_valid=0, result=0, busy=0, internal accumulators=0. in_ready=1 while rst is high and flush is low.
- Op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 0/1), 9 SLTU.
  - 10 MUL, 11 DIVU, 12 REMU.
  - 13-15 reserved: result=0, single-cycle latency.
- Shifts use b[SHW-1:0] only; upper bits of b are ignored. SRA is arithmetic (sign fill). ADD/SUB/MUL wrap modulo 2^XLEN.
- Accept occurs when in_valid & in_ready at edge T; op, a and b are captured and ignored afterwards.
- States:
  - IDLE: on accept, single-cycle ops compute, result registers, go to DONE. out_valid=1 at T+1.
  - IDLE: on accept of MUL, DIVU or REMU with b!=0, load operands, counter=XLEN-1, go to CALC.
  - CALC: one shift-add (MUL) or one restoring subtract step (DIVU/REMU) per cycle. When counter hits 0, result registers and state goes to DONE. out_valid=1 at T+XLEN+1 (T+33 for XLEN=32).
  - DONE: out_valid=1 and result held stable until out_ready=1, then return to IDLE. in_ready is low in DONE, so minimum spacing is 2 cycles per op.
- Divide by zero, detected at accept, no iteration, DONE at T+1:
  - DIVU result = all ones.
  - REMU result = a.
- flush=1 at any edge with state != IDLE: next state IDLE, out_valid=0, result unchanged, in-flight op discarded.
- flush=1 in IDLE: in_ready=0, so nothing is accepted. flush wins over a simultaneous in_valid.
- flush and out_ready both high in DONE: result is dropped; the consumer must not sample it.
- rst mid-operation: all state clears immediately (asynchronous). No result is produced after release.
- out_ready while out_valid=0 has no effect. in_valid while in_ready=0 has no effect; the source must hold its operands.

Test Plan:
1. ADD a=0xFFFFFFFF, b=0x00000001 accepted at T -> out_valid at T+1, result=0x00000000. SLT a=0xFFFFFFFF, b=0 -> 1; SLTU same operands -> 0.
2. SRA a=0x80000000, b=0x00000024 -> result=0xF8000000 (shift 4, upper b bits ignored). SRL same operands -> 0x08000000.
3. MUL a=0x00010003, b=0x00000005 accepted at T -> out_valid first high at T+33, result=0x0005000F. in_ready=0 for T+1..T+33.
4. DIVU 100/7 -> 14 and REMU 100/7 -> 2, each at T+33. DIVU 5/0 -> 0xFFFFFFFF at T+1. REMU 5/0 -> 0x00000005 at T+1.
5. Backpressure: ADD 3+4, hold out_ready=0 for 5 cycles -> out_valid=1 and result=7 stable throughout, in_ready=0. Release -> IDLE next cycle, in_ready=1.
6. DIVU started, flush at T+10 -> out_valid never rises, in_ready=1 at T+11. Repeat with rst pulsed at T+10 -> out_valid=0, result=0 immediately.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle execute-stage ALU. Single-cycle logic and shift ops finish in one cycle.
// MUL, DIVU and REMU iterate over a shared XLEN-step shift-add / restoring-divide datapath.
module alu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [XLEN-1:0]  accA_q, accA_d;
    logic [XLEN-1:0]  accB_q, accB_d;
    logic [XLEN-1:0]  opnd_q, opnd_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             mulOp_q, mulOp_d;
    logic             remOp_q, remOp_d;

    logic [SHW-1:0]   shamt;
    logic [XLEN-1:0]  aluRes;
    logic [XLEN-1:0]  mulSum;
    logic [XLEN:0]    remShift;
    logic             divGe;
    logic [XLEN-1:0]  remNext;
    logic [XLEN-1:0]  quoNext;
    logic             startIter;

    assign in_ready  = (state_q == IDLE) && !flush;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;

    // The DIVU/REMU entries only matter for a zero divisor; non-zero divisors iterate.
    always_comb begin
        shamt  = b[SHW-1:0];
        aluRes = '0;
        case (op)
            OP_ADD:  aluRes = a + b;
            OP_SUB:  aluRes = a - b;
            OP_AND:  aluRes = a & b;
            OP_OR:   aluRes = a | b;
            OP_XOR:  aluRes = a ^ b;
            OP_SLL:  aluRes = a << shamt;
            OP_SRL:  aluRes = a >> shamt;
            OP_SRA:  aluRes = $signed(a) >>> shamt;
            OP_SLT:  aluRes = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: aluRes = {{(XLEN-1){1'b0}}, (a < b)};
            OP_DIVU: aluRes = '1;
            OP_REMU: aluRes = a;
            default: aluRes = '0;
        endcase
    end

    // accA holds the product accumulator or partial remainder, accB the shifting
    // multiplicand or dividend/quotient, opnd the shifting multiplier or divisor.
    always_comb begin
        mulSum   = accA_q + (opnd_q[0] ? accB_q : '0);
        remShift = {accA_q, accB_q[XLEN-1]};
        divGe    = (remShift >= {1'b0, opnd_q});
        remNext  = divGe ? XLEN'(remShift - {1'b0, opnd_q}) : remShift[XLEN-1:0];
        quoNext  = {accB_q[XLEN-2:0], divGe};
    end

    assign startIter = (op == OP_MUL) || (((op == OP_DIVU) || (op == OP_REMU)) && (b != '0));

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        accA_d   = accA_q;
        accB_d   = accB_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        mulOp_d  = mulOp_q;
        remOp_d  = remOp_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (startIter) begin
                            accA_d  = '0;
                            accB_d  = a;
                            opnd_d  = b;
                            cnt_d   = SHW'(XLEN - 1);
                            mulOp_d = (op == OP_MUL);
                            remOp_d = (op == OP_REMU);
                            state_d = CALC;
                        end else begin
                            result_d = aluRes;
                            state_d  = DONE;
                        end
                    end
                end
                CALC: begin
                    cnt_d = cnt_q - 1'b1;
                    if (mulOp_q) begin
                        accA_d = mulSum;
                        accB_d = accB_q << 1;
                        opnd_d = opnd_q >> 1;
                    end else begin
                        accA_d = remNext;
                        accB_d = quoNext;
                    end
                    if (cnt_q == '0) begin
                        state_d  = DONE;
                        result_d = mulOp_q ? mulSum : (remOp_q ? remNext : quoNext);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            accA_q   <= '0;
            accB_q   <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            mulOp_q  <= 1'b0;
            remOp_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            accA_q   <= accA_d;
            accB_q   <= accB_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            mulOp_q  <= mulOp_d;
            remOp_q  <= remOp_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard testbench for alu_seq: expected results are queued when an op is
// driven and popped when the DUT presents a result.
module tb_alu_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int nVec = 0;
    int nMis = 0;
    logic [31:0] expQ[$];

    alu_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        case (o)
            4'd0:  r = x + y;
            4'd1:  r = x - y;
            4'd2:  r = x & y;
            4'd3:  r = x | y;
            4'd4:  r = x ^ y;
            4'd5:  r = x << y[4:0];
            4'd6:  r = x >> y[4:0];
            4'd7:  r = $signed(x) >>> y[4:0];
            4'd8:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd9:  r = (x < y) ? 32'd1 : 32'd0;
            4'd10: r = x * y;
            4'd11: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            4'd12: r = (y == 0) ? x : x % y;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic int latency(input logic [3:0] o, input logic [31:0] y);
        if (o == 4'd10) return 33;
        if ((o == 4'd11 || o == 4'd12) && y != 0) return 33;
        return 1;
    endfunction

    // Presents one op and lets it be accepted on the next rising edge.
    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        a = $urandom; b = $urandom; op = 4'($urandom_range(15, 0));
    endtask

    // Waits (bounded) for out_valid; lat counts sampled cycles after the accept edge.
    task automatic waitOut(output int lat, output logic [31:0] res, output bit readySeen);
        lat = 0;
        readySeen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (in_ready && !out_valid) readySeen = 1'b1;
        end while (!out_valid && lat < 100);
        res = result;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic runOp(input string name, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int lat;
        logic [31:0] res;
        logic [31:0] expd;
        bit rdy;
        expQ.push_back(model(o, x, y));
        applyStimulus(o, x, y);
        waitOut(lat, res, rdy);
        expd = expQ.pop_front();
        nVec++;
        if (res !== expd) begin
            nMis++;
            $display("[TB] FAIL %s result: got %h expected %h", name, res, expd);
        end
        nVec++;
        if (lat !== latency(o, y)) begin
            nMis++;
            $display("[TB] FAIL %s latency: got %0d expected %0d", name, lat, latency(o, y));
        end
        consume();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; op = 4'd0; a = '0; b = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        nVec++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            nMis++; $display("[TB] FAIL reset_flags: got valid=%b busy=%b expected 0 0", out_valid, busy);
        end
        nVec++;
        if (result !== 32'd0) begin
            nMis++; $display("[TB] FAIL reset_result: got %h expected 0", result);
        end
        nVec++;
        if (in_ready !== 1'b1) begin
            nMis++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        flush = 1'b1;
        #1;
        nVec++;
        if (in_ready !== 1'b0) begin
            nMis++; $display("[TB] FAIL reset_flush_ready: got %b expected 0", in_ready);
        end
        flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu_basic();
        logic [3:0]  ops[8] = '{4'd0, 4'd8, 4'd9, 4'd1, 4'd2, 4'd3, 4'd4, 4'd13};
        logic [31:0] as[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0005,
                               32'hF0F0_1234, 32'h0F00_00A0, 32'hAAAA_5555, 32'h1234_5678};
        logic [31:0] bs[8]  = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0009,
                               32'hFF00_FF00, 32'h0000_0F0F, 32'hFFFF_0000, 32'h8765_4321};
        for (int i = 0; i < 8; i++) runOp("basic", ops[i], as[i], bs[i]);
    endtask

    task automatic test_shifts();
        runOp("sra", 4'd7, 32'h8000_0000, 32'h0000_0024);
        runOp("srl", 4'd6, 32'h8000_0000, 32'h0000_0024);
        runOp("sll", 4'd5, 32'h0000_0081, 32'hFFFF_FFE7);
        runOp("sra_pos", 4'd7, 32'h7000_0000, 32'h0000_001F);
    endtask

    task automatic test_mul();
        int lat;
        logic [31:0] res;
        logic [31:0] expd;
        bit rdy;
        expQ.push_back(model(4'd10, 32'h0001_0003, 32'h0000_0005));
        applyStimulus(4'd10, 32'h0001_0003, 32'h0000_0005);
        waitOut(lat, res, rdy);
        expd = expQ.pop_front();
        nVec++;
        if (res !== expd || lat !== 33) begin
            nMis++; $display("[TB] FAIL mul: got %h@%0d expected %h@33", res, lat, expd);
        end
        nVec++;
        if (rdy !== 1'b0) begin
            nMis++; $display("[TB] FAIL mul_in_ready: got in_ready=1 during calc expected 0");
        end
        consume();
        for (int i = 0; i < 3; i++) runOp("mul_rand", 4'd10, $urandom, $urandom);
    endtask

    task automatic test_div();
        runOp("divu", 4'd11, 32'd100, 32'd7);
        runOp("remu", 4'd12, 32'd100, 32'd7);
        runOp("divu_zero", 4'd11, 32'd5, 32'd0);
        runOp("remu_zero", 4'd12, 32'd5, 32'd0);
        runOp("divu_big", 4'd11, 32'hFFFF_FFFF, 32'h8000_0001);
        for (int i = 0; i < 2; i++) begin
            runOp("divu_rand", 4'd11, $urandom, 32'($urandom_range(65535, 1)));
            runOp("remu_rand", 4'd12, $urandom, 32'($urandom_range(65535, 1)));
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] res;
        logic [31:0] expd;
        bit rdy;
        bit bad;
        expQ.push_back(model(4'd0, 32'd3, 32'd4));
        applyStimulus(4'd0, 32'd3, 32'd4);
        waitOut(lat, res, rdy);
        expd = expQ.pop_front();
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || result !== expd || in_ready !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        nVec++;
        if (bad) begin
            nMis++; $display("[TB] FAIL backpressure_hold: got valid=%b result=%h expected 1 %h", out_valid, result, expd);
        end
        consume();
        @(negedge clk);
        nVec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            nMis++; $display("[TB] FAIL backpressure_release: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_flush();
        bit rose;
        int lat;
        logic [31:0] res;
        bit rdy;
        logic [31:0] expd;
        applyStimulus(4'd11, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        nVec++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            nMis++; $display("[TB] FAIL flush_calc: got ready=%b busy=%b expected 1 0", in_ready, busy);
        end
        rose = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) rose = 1'b1;
        end
        nVec++;
        if (rose !== 1'b0) begin
            nMis++; $display("[TB] FAIL flush_no_result: got out_valid=1 expected 0");
        end
        // flush in IDLE beats a simultaneous in_valid
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1;
        #1;
        nVec++;
        if (in_ready !== 1'b0) begin
            nMis++; $display("[TB] FAIL flush_idle_ready: got %b expected 0", in_ready);
        end
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        nVec++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            nMis++; $display("[TB] FAIL flush_idle_accept: got busy=%b valid=%b expected 0 0", busy, out_valid);
        end
        // flush together with out_ready in DONE drops the result
        expQ.push_back(model(4'd1, 32'd50, 32'd8));
        applyStimulus(4'd1, 32'd50, 32'd8);
        waitOut(lat, res, rdy);
        expd = expQ.pop_front();
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        nVec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== expd) begin
            nMis++; $display("[TB] FAIL flush_done: got valid=%b ready=%b result=%h expected 0 1 %h", out_valid, in_ready, result, expd);
        end
    endtask

    task automatic test_rst_mid();
        bit rose;
        applyStimulus(4'd11, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        nVec++;
        if (out_valid !== 1'b0 || result !== 32'd0 || busy !== 1'b0) begin
            nMis++; $display("[TB] FAIL rst_mid: got valid=%b result=%h busy=%b expected 0 0 0", out_valid, result, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        rose = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) rose = 1'b1;
        end
        nVec++;
        if (rose !== 1'b0 || in_ready !== 1'b1) begin
            nMis++; $display("[TB] FAIL rst_mid_after: got rose=%b ready=%b expected 0 1", rose, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            logic [3:0] o;
            logic [31:0] x;
            logic [31:0] y;
            o = 4'($urandom_range(15, 0));
            x = $urandom;
            y = (i % 3 == 0) ? 32'd0 : $urandom;
            runOp("b2b", o, x, y);
        end
    endtask

    initial begin
        test_reset();
        test_alu_basic();
        test_shifts();
        test_mul();
        test_div();
        test_backpressure();
        test_flush();
        test_rst_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
